// File: rtl/clock_div_prog.sv
// Programmable clock divider: divided clock, per-period tick and a slow tick every SUB_DIV ticks.
// All outputs come straight from flops; the divisor can be reloaded at run time.
module clock_div_prog #(
  parameter int unsigned WIDTH       = 17,
  parameter int unsigned DEFAULT_DIV = 100000,
  parameter int unsigned SUB_DIV     = 1000
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             div_load_i,
  input  logic [WIDTH-1:0] div_val_i,
  output logic             clk_out_o,
  output logic             tick_o,
  output logic             tick_slow_o,
  output logic             div_err_o
);

  localparam int unsigned SubW = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;
  localparam logic [SubW-1:0] SubMax = SubW'(SUB_DIV - 1);
  localparam logic [WIDTH-1:0] DivRst = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] DivMin = WIDTH'(2);
  localparam logic [WIDTH-1:0] One = WIDTH'(1);

  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [SubW-1:0]  sub_q, sub_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             tick_slow_q, tick_slow_d;
  logic             div_err_q, div_err_d;
  logic             load_ok;
  logic             wrap;

  always_comb begin
    div_d       = div_q;
    cnt_d       = cnt_q;
    sub_d       = sub_q;
    tick_d      = 1'b0;
    tick_slow_d = 1'b0;
    div_err_d   = 1'b0;
    wrap        = 1'b0;
    load_ok     = div_load_i && (div_val_i >= DivMin);

    if (load_ok) begin
      // An accepted load restarts the period and wins over any wrap or tick.
      div_d = div_val_i;
      cnt_d = '0;
      sub_d = '0;
    end else begin
      div_err_d = div_load_i;
      if (en_i) begin
        wrap  = (cnt_q == div_q - One);
        cnt_d = wrap ? '0 : cnt_q + One;
        // Tick is registered so it is high while the counter sits on its last count.
        if (cnt_d == div_q - One) begin
          tick_d      = 1'b1;
          tick_slow_d = (sub_q == SubMax);
          sub_d       = (sub_q == SubMax) ? '0 : sub_q + SubW'(1);
        end
      end
    end

    // Low for ceil(div/2) counts, high for floor(div/2) counts.
    clk_out_d = (cnt_d >= (div_d - (div_d >> 1)));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q       <= DivRst;
      cnt_q       <= '0;
      sub_q       <= '0;
      clk_out_q   <= 1'b0;
      tick_q      <= 1'b0;
      tick_slow_q <= 1'b0;
      div_err_q   <= 1'b0;
    end else begin
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      sub_q       <= sub_d;
      clk_out_q   <= clk_out_d;
      tick_q      <= tick_d;
      tick_slow_q <= tick_slow_d;
      div_err_q   <= div_err_d;
    end
  end

  assign clk_out_o   = clk_out_q;
  assign tick_o      = tick_q;
  assign tick_slow_o = tick_slow_q;
  assign div_err_o   = div_err_q;

endmodule

// File: tb/tb_clock_div_prog.sv
// Bench for clock_div_prog with WIDTH=8, DEFAULT_DIV=4, SUB_DIV=3.
// Expected {clk_out, tick, tick_slow, div_err} are queued per cycle and compared after each edge.
module tb_clock_div_prog;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       div_load;
  logic [7:0] div_val;
  logic       clk_out;
  logic       tick;
  logic       tick_slow;
  logic       div_err;

  logic [3:0] sb[$];
  logic [3:0] got;
  logic [3:0] exp_v;
  int         n_tests = 0;
  int         n_fail = 0;

  clock_div_prog #(
    .WIDTH      (8),
    .DEFAULT_DIV(4),
    .SUB_DIV    (3)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .en_i       (en),
    .div_load_i (div_load),
    .div_val_i  (div_val),
    .clk_out_o  (clk_out),
    .tick_o     (tick),
    .tick_slow_o(tick_slow),
    .div_err_o  (div_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b1; en = 1'b0; div_load = 1'b0; div_val = 8'd0;
    #2 rst_n = 1'b0;
    #1;
    got = {clk_out, tick, tick_slow, div_err};
    n_tests++;
    if (got !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_async: got %b expected %b", got, 4'b0000);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    // Counter must not move while en is low after release.
    for (int i = 0; i < 2; i++) begin
      en = 1'b0;
      sb.push_back(4'b0000);
      @(posedge clk); #1;
      got = {clk_out, tick, tick_slow, div_err};
      exp_v = sb.pop_front();
      n_tests++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL reset_hold step %0d: got %b expected %b", i, got, exp_v);
      end
    end
  endtask

  task automatic test_run();
    for (int k = 1; k <= 24; k++) begin
      en = 1'b1; div_load = 1'b0;
      sb.push_back({(k % 4) >= 2, (k % 4) == 3, (k % 12) == 11, 1'b0});
      @(posedge clk); #1;
      got = {clk_out, tick, tick_slow, div_err};
      exp_v = sb.pop_front();
      n_tests++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL run cycle %0d: got %b expected %b", k, got, exp_v);
      end
    end
  endtask

  task automatic test_reject();
    for (int k = 1; k <= 12; k++) begin
      en = 1'b1;
      div_load = (k == 2) || (k == 6);
      div_val = (k == 2) ? 8'd1 : 8'd0;
      sb.push_back({(k % 4) >= 2, (k % 4) == 3, (k % 12) == 11, (k == 2) || (k == 6)});
      @(posedge clk); #1;
      got = {clk_out, tick, tick_slow, div_err};
      exp_v = sb.pop_front();
      n_tests++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL reject cycle %0d: got %b expected %b", k, got, exp_v);
      end
    end
    div_load = 1'b0;
  endtask

  task automatic test_en_hold();
    bit [7:0] enp = 8'b1110_0011;
    bit [7:0] clkp = 8'b0011_1110;
    bit [7:0] tickp = 8'b0010_0000;
    for (int i = 0; i < 8; i++) begin
      en = enp[i]; div_load = 1'b0;
      sb.push_back({clkp[i], tickp[i], 1'b0, 1'b0});
      @(posedge clk); #1;
      got = {clk_out, tick, tick_slow, div_err};
      exp_v = sb.pop_front();
      n_tests++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL en_hold step %0d: got %b expected %b", i, got, exp_v);
      end
    end
  endtask

  task automatic test_load_wrap();
    int c;
    // cnt 1 -> 2, then load 6 on the edge that would have produced the tick.
    for (int i = 0; i < 2; i++) begin
      en = 1'b1;
      div_load = (i == 1);
      div_val = 8'd6;
      sb.push_back((i == 0) ? 4'b1000 : 4'b0000);
      @(posedge clk); #1;
      got = {clk_out, tick, tick_slow, div_err};
      exp_v = sb.pop_front();
      n_tests++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL load_wrap step %0d: got %b expected %b", i, got, exp_v);
      end
    end
    div_load = 1'b0;
    for (int j = 1; j <= 18; j++) begin
      c = j % 6;
      en = 1'b1;
      sb.push_back({c >= 3, c == 5, j == 17, 1'b0});
      @(posedge clk); #1;
      got = {clk_out, tick, tick_slow, div_err};
      exp_v = sb.pop_front();
      n_tests++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL div6 cycle %0d: got %b expected %b", j, got, exp_v);
      end
    end
  endtask

  task automatic test_load5();
    int c;
    en = 1'b0; div_load = 1'b1; div_val = 8'd5;
    sb.push_back(4'b0000);
    @(posedge clk); #1;
    got = {clk_out, tick, tick_slow, div_err};
    exp_v = sb.pop_front();
    n_tests++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL load5_en_low: got %b expected %b", got, exp_v);
    end
    div_load = 1'b0;
    for (int j = 1; j <= 15; j++) begin
      c = j % 5;
      en = 1'b1;
      sb.push_back({c >= 3, c == 4, j == 14, 1'b0});
      @(posedge clk); #1;
      got = {clk_out, tick, tick_slow, div_err};
      exp_v = sb.pop_front();
      n_tests++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL div5 cycle %0d: got %b expected %b", j, got, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int j = 1; j <= 3; j++) begin
      en = 1'b1; div_load = 1'b0;
      sb.push_back({j >= 3, 1'b0, 1'b0, 1'b0});
      @(posedge clk); #1;
      got = {clk_out, tick, tick_slow, div_err};
      exp_v = sb.pop_front();
      n_tests++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL pre_reset cycle %0d: got %b expected %b", j, got, exp_v);
      end
    end
    rst_n = 1'b0;
    #1;
    got = {clk_out, tick, tick_slow, div_err};
    n_tests++;
    if (got !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_mid_async: got %b expected %b", got, 4'b0000);
    end
    #1 rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      en = 1'b1;
      sb.push_back({(k % 4) >= 2, (k % 4) == 3, k == 11, 1'b0});
      @(posedge clk); #1;
      got = {clk_out, tick, tick_slow, div_err};
      exp_v = sb.pop_front();
      n_tests++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL post_reset cycle %0d: got %b expected %b", k, got, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_run();
    test_reject();
    test_en_hold();
    test_load_wrap();
    test_load5();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_div_prog.md
CLOCK_DIV_PROG -- requirements
Module: clock_div_prog

Interface
REQ-001 Parameter WIDTH, default 17: divisor and counter width in bits.
REQ-002 Parameter DEFAULT_DIV, default 100000: divisor after reset; legal range 2..2^WIDTH-1 (100 MHz to 1 kHz).
REQ-003 Parameter SUB_DIV, default 1000: number of ticks per slow tick; legal range >= 1 (1 kHz to 1 Hz).
REQ-004 clk  input  1  system clock; all flops rising-edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 en  input  1  count enable.
REQ-007 div_load  input  1  one-cycle strobe; loads div_val.
REQ-008 div_val  input  WIDTH  new divisor, sampled when div_load=1.
REQ-009 clk_out  output  1  divided clock, near-50% duty, driven directly by a flop.
REQ-010 tick  output  1  one-cycle pulse per divided period.
REQ-011 tick_slow  output  1  one-cycle pulse every SUB_DIV ticks.
REQ-012 div_err  output  1  one-cycle pulse on a rejected load.

Function
REQ-013 Internal state SHALL be: div_r (WIDTH bits), cnt (WIDTH bits, range 0..div_r-1), and sub_cnt (range 0..SUB_DIV-1).
REQ-014 With en=1 and no load, each cycle cnt SHALL advance as follows: cnt <= (cnt==div_r-1) ? 0 : cnt+1.
REQ-015 clk_out SHALL equal (cnt >= div_r - floor(div_r/2)) in every cycle, computed from the next-state cnt into the flop.
REQ-016 Consequently, clk_out SHALL be low for ceil(div_r/2) cycles and high for floor(div_r/2) cycles of each period.
REQ-017 tick SHALL be 1 exactly in cycles where cnt==div_r-1 and en=1; otherwise 0. tick SHALL be registered (computed from next state).
REQ-018 sub_cnt SHALL advance once per tick and wrap to 0 after SUB_DIV-1.
REQ-019 tick_slow SHALL be 1 only in a cycle where tick=1 and sub_cnt==SUB_DIV-1. With SUB_DIV=1, tick_slow SHALL equal tick.
REQ-020 With en=0: cnt, sub_cnt and clk_out SHALL hold their values; tick and tick_slow SHALL be 0.
REQ-021 div_load=1 with div_val>=2 SHALL, at the next edge, set div_r=div_val and cnt=0 and sub_cnt=0, and force clk_out=0, tick=0, tick_slow=0. The load is accepted regardless of en.
REQ-022 div_load=1 with div_val<2 SHALL leave all state unchanged, with counting continuing per en, and SHALL assert div_err for exactly one cycle.
REQ-023 A load coinciding with a wrap SHALL take priority: no tick and no sub_cnt advance in that cycle.
REQ-024 div_err SHALL be 0 in every cycle that has no rejected load.
REQ-025 No output SHALL be combinational from any input.

Reset
REQ-026 While rst=0, the block SHALL immediately set div_r=DEFAULT_DIV, cnt=0, sub_cnt=0, and clk_out=tick=tick_slow=div_err=0.
REQ-027 Reset asserted mid-period SHALL discard any previously loaded divisor.
REQ-028 After rst rises, the first cnt increment SHALL occur on the first clk edge with en=1.

Verification (WIDTH=8, DEFAULT_DIV=4, SUB_DIV=3)
REQ-029 Release reset, en=1 constantly -> clk_out reads 0,0,1,1 repeating; tick high on cycles 3, 7, 11 after release; tick_slow high only on cycle 11, then every 12 cycles.
REQ-030 Load div_val=5 -> next cycle cnt=0 and clk_out=0; thereafter clk_out is low 3 cycles, high 2 cycles; tick every 5th cycle.
REQ-031 Load div_val=1 mid-period -> div_err high for 1 cycle; period stays 4 and phase is undisturbed.
REQ-032 Drop en for 3 cycles while cnt=2 -> clk_out held at 1, tick=0 throughout; the next tick arrives 1 enabled cycle after en returns.
REQ-033 Assert load of 6 in the same cycle cnt==3 -> no tick that cycle; the new period of 6 starts with cnt=0.
REQ-034 Pulse rst low for 2 ns mid-period after a load of 5 -> all outputs 0 immediately; the period is 4 after release.
